// File: rtl/adc_pkg.sv
// Shared definitions for the dual-ADC capture front end: sample width,
// state encoding and default timing.
package adc_pkg;

    localparam int ADC_W            = 13;
    localparam int SAMPLE_DIV_DEF   = 10;
    localparam int CONV_TIMEOUT_DEF = 4;
    localparam int RD_CYCLES_DEF    = 2;
    localparam int CNT_W_DEF        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVST,
        ST_CONV_WAIT,
        ST_READ,
        ST_HOLD
    } adc_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous control level.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_dual_capture.sv
// Sequences two parallel ADCs sharing convst/cs/rd strobes and latches both
// buses into registered outputs with a per-sample valid pulse.
//
// state      | meaning
// IDLE       | strobes released, waiting for synchronised run level
// CONVST     | one-cycle conversion start pulse; period counter restarts
// CONV_WAIT  | waiting for busy to fall (first cycle ignored) or timeout
// READ       | cs/rd low; both buses latched on the last cycle
// HOLD       | strobes released until the sample period ends
module adc_dual_capture
    import adc_pkg::*;
#(
    parameter int SAMPLE_DIV   = SAMPLE_DIV_DEF,
    parameter int CONV_TIMEOUT = CONV_TIMEOUT_DEF,
    parameter int RD_CYCLES    = RD_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             CLK25M,
    input  logic             RST,
    input  logic             start_adc,
    input  logic             adc_busy,
    input  logic [ADC_W-1:0] adc_d1,
    input  logic [ADC_W-1:0] adc_d2,
    output logic             adc_convst_n,
    output logic             adc_cs_n,
    output logic             adc_rd_n,
    output logic [ADC_W-1:0] data1,
    output logic [ADC_W-1:0] data2,
    output logic             sample_valid,
    output logic [CNT_W-1:0] sample_count,
    output logic             timeout_err
);

    localparam int PER_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int STEP_MAX = (CONV_TIMEOUT > RD_CYCLES) ? CONV_TIMEOUT : RD_CYCLES;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);

    adc_state_e        state, state_nx;
    logic [PER_W-1:0]  per_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic              run_s;
    logic              latch;
    logic              timeout_hit;

    sync2 u_run_sync (
        .clk (CLK25M),
        .rst (RST),
        .d   (start_adc),
        .q   (run_s)
    );

    always_comb begin
        state_nx     = state;
        adc_convst_n = 1'b1;
        adc_cs_n     = 1'b1;
        adc_rd_n     = 1'b1;
        latch        = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_s) state_nx = ST_CONVST;
            end
            ST_CONVST: begin
                adc_convst_n = 1'b0;
                state_nx     = ST_CONV_WAIT;
            end
            ST_CONV_WAIT: begin
                // busy is not trusted on the first cycle after the convst pulse
                if (step_cnt != '0 && !adc_busy) begin
                    state_nx = ST_READ;
                end else if (step_cnt == STEP_W'(CONV_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nx    = ST_HOLD;
                end
            end
            ST_READ: begin
                adc_cs_n = 1'b0;
                adc_rd_n = 1'b0;
                if (step_cnt == STEP_W'(RD_CYCLES - 1)) begin
                    latch    = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (per_cnt == PER_W'(SAMPLE_DIV - 1))
                    state_nx = run_s ? ST_CONVST : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK25M) begin
        if (RST) begin
            state        <= ST_IDLE;
            per_cnt      <= '0;
            step_cnt     <= '0;
            data1        <= '0;
            data2        <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            step_cnt <= (state_nx != state) ? '0 : step_cnt + 1'b1;

            if (state_nx == ST_CONVST && state != ST_CONVST)
                per_cnt <= '0;
            else if (state != ST_IDLE)
                per_cnt <= (per_cnt == PER_W'(SAMPLE_DIV - 1)) ? '0 : per_cnt + 1'b1;

            sample_valid <= latch;
            if (latch) begin
                data1        <= adc_d1;
                data2        <= adc_d2;
                sample_count <= sample_count + 1'b1;
            end
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

endmodule

// File: doc/adc_dual_capture.md
Name: adc_dual_capture

Overview:
- Front-end stage that sequences two parallel 13-bit ADCs sharing one control strobe set.
- Issues periodic conversions while enabled, reads both ADC buses during a read window, and latches them into registered outputs.
- Feeds the PPI multiplexer stage directly, so that stage always sees stable, non-tristated data1/data2 plus a per-sample valid pulse.
- Runs entirely in the CLK25M domain.

Parameters:
- SAMPLE_DIV, 10, CLK25M cycles per sample period (2.5 MS/s at default); must be >= CONV_TIMEOUT + RD_CYCLES + 3.
- CONV_TIMEOUT, 4, maximum cycles to wait for adc_busy to fall after convst.
- RD_CYCLES, 2, cycles adc_rd_n is held low; data is sampled on the last cycle.
- CNT_W, 16, width of sample_count.

Ports:
- CLK25M  input  1  system clock, 25 MHz.
- RST  input  1  synchronous active-high reset.
- start_adc  input  1  asynchronous enable level; sampling runs while high.
- adc_busy  input  1  ADC busy, high during conversion (shared by both ADCs).
- adc_d1  input  13  ADC 1 parallel data; valid only while adc_rd_n is low.
- adc_d2  input  13  ADC 2 parallel data; valid only while adc_rd_n is low.
- adc_convst_n  output  1  conversion start, active low.
- adc_cs_n  output  1  chip select, active low.
- adc_rd_n  output  1  read strobe, active low.
- data1  output  13  latched ADC 1 sample.
- data2  output  13  latched ADC 2 sample.
- sample_valid  output  1  one-cycle pulse when data1/data2 update.
- sample_count  output  CNT_W  count of samples latched; wraps at 2^CNT_W.
- timeout_err  output  1  sticky flag: a conversion hit CONV_TIMEOUT.

Behaviour:
- Reset (synchronous, RST high at a CLK25M edge) produces:
  - state IDLE;
  - adc_convst_n=1, adc_cs_n=1, adc_rd_n=1;
  - data1=0, data2=0, sample_valid=0, sample_count=0, timeout_err=0;
  - period counter=0; synchroniser flops=0.
- start_adc passes through a 2-flop synchroniser (run_s) before use, adding 2 cycles of latency.
- A free period counter runs 0..SAMPLE_DIV-1 whenever state != IDLE, and is cleared on entering CONVST.
- State machine:
  - IDLE: all strobes deasserted. If run_s=1, go to CONVST.
  - CONVST (1 cycle): adc_convst_n=0. Go to CONV_WAIT; the wait counter is cleared.
  - CONV_WAIT: adc_convst_n=1.
    - adc_busy is ignored on the first cycle.
    - From the second cycle on, adc_busy=0 goes to READ.
    - If the wait counter reaches CONV_TIMEOUT with busy still high: set timeout_err, skip the read, go to HOLD.
  - READ (RD_CYCLES cycles): adc_cs_n=0, adc_rd_n=0.
    - On the last READ cycle, adc_d1/adc_d2 are registered into data1/data2.
    - On that same edge: sample_valid=1 for the next cycle and sample_count increments.
    - Then go to HOLD.
  - HOLD: strobes deasserted; data1/data2 held.
    - When the period counter reaches SAMPLE_DIV-1: if run_s=1 go to CONVST, else go to IDLE.
- Sample rate: convst falling edges are exactly SAMPLE_DIV cycles apart while run_s stays high.
- start_adc falling mid-sample: the current sample completes normally, including the latch and valid pulse; the block then returns to IDLE at the period end.
- data1/data2 never change except on a latch edge. The high-impedance or undriven ADC bus between reads must never reach the outputs.
- sample_count wraps from 2^CNT_W-1 to 0 with no flag.
- timeout_err is cleared only by RST. A timed-out period produces no sample_valid and no count change.
- RST asserted mid-sample: all outputs go to their reset values on that edge, and strobes release immediately.

Decomposition:
- Shared package adc_pkg:
  - state encoding constants (IDLE, CONVST, CONV_WAIT, READ, HOLD);
  - ADC_W=13;
  - default timing constants.
- One sub-module, sync2: the 2-flop synchroniser for start_adc, reusable for other asynchronous controls.

Test Plan:
- Reset then hold start_adc=0 for 50 cycles -> all strobes stay 1, data1=data2=0, sample_valid never asserts.
- start_adc=1; ADC model drops busy 3 cycles after convst and drives adc_d1=13'h1666, adc_d2=13'h0999 only while rd_n=0 (Z otherwise).
  - Required: data1=13'h1666, data2=13'h0999 one cycle after the last rd_n-low cycle.
  - Required: sample_valid is a single-cycle pulse and sample_count=1.
  - Required: convst falling edges are 10 cycles apart.
- Run 4 samples alternating 13'h1FFF/13'h0000 and 13'h0000/13'h1FFF, with the buses Z between reads -> outputs never show X/Z; sample_count=4.
- Hold adc_busy=1 permanently for one period -> timeout_err=1 after 4 wait cycles, no sample_valid, data held at the previous values, the next period proceeds normally.
- Deassert start_adc during READ -> the sample still latches, the block enters IDLE at the period end, and no further convst occurs.
- Preload sample_count near wrap (CNT_W=4, run 17 samples) -> count goes 15 to 0; assert RST during CONV_WAIT -> strobes are 1 on the next edge and all outputs are 0.
